// File: rtl/md_if.sv
// Hazard/EX-side bundle for the multiply/divide unit. The EX stage and the
// stall unit drive the master end. md_unit is the slave end.
interface md_if #(
   parameter int WIDTH = 32
);
   logic             startE;
   logic [2:0]       mdOpE;
   logic [WIDTH-1:0] srcAE;
   logic [WIDTH-1:0] srcBE;
   logic             readHiLoD;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             mdStall;

   modport master (
      output startE, mdOpE, srcAE, srcBE, readHiLoD,
      input  hi, lo, busy, mdStall
   );

   modport slave (
      input  startE, mdOpE, srcAE, srcBE, readHiLoD,
      output hi, lo, busy, mdStall
   );
endinterface

// File: rtl/md_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
// A MULT/DIV occupies WIDTH CALC cycles and one FIX cycle. mdStall holds the
// front of the pipeline while the unit is busy.
module md_unit #(
   parameter int WIDTH    = 32,
   parameter int CNT_BITS = 6
) (
   input logic clk,
   input logic rst,
   md_if.slave mdBus
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6
   } mdOp_t;

   localparam logic [CNT_BITS-1:0] LAST_STEP = CNT_BITS'(WIDTH - 1);

   state_t              state, nextState;
   mdOp_t               opE;
   logic                isArithE, isSignedE, isDivE, signAE, signBE;
   logic [WIDTH-1:0]    magA, magB;

   logic [CNT_BITS-1:0] cnt;
   logic [WIDTH-1:0]    opA, opB;
   logic [2*WIDTH-1:0]  acc;
   logic [WIDTH-1:0]    rem;
   logic                isDiv, negRes, negRem, divZero;

   logic [WIDTH:0]      mulSum, remShift, remDiff;
   logic [2*WIDTH-1:0]  prod;
   logic [WIDTH-1:0]    quoFix, remFix;

   // Decode the EX-stage op and form operand magnitudes
   always_comb begin
      opE       = mdOp_t'(mdBus.mdOpE);
      isArithE  = (opE == OP_MULT) || (opE == OP_MULTU) ||
                  (opE == OP_DIV)  || (opE == OP_DIVU);
      isSignedE = (opE == OP_MULT) || (opE == OP_DIV);
      isDivE    = (opE == OP_DIV)  || (opE == OP_DIVU);
      signAE    = isSignedE & mdBus.srcAE[WIDTH-1];
      signBE    = isSignedE & mdBus.srcBE[WIDTH-1];
      magA      = signAE ? -mdBus.srcAE : mdBus.srcAE;
      magB      = signBE ? -mdBus.srcBE : mdBus.srcBE;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   // Next-state, busy and stall request
   always_comb begin
      nextState     = state;
      mdBus.busy    = (state != IDLE);
      mdBus.mdStall = 1'b0;
      case (state)
         IDLE: begin
            if (mdBus.startE && isArithE) nextState = CALC;
            mdBus.mdStall = mdBus.startE & isArithE & mdBus.readHiLoD;
         end
         CALC: begin
            if (cnt == LAST_STEP) nextState = FIX;
            mdBus.mdStall = mdBus.startE | mdBus.readHiLoD;
         end
         FIX: begin
            nextState     = IDLE;
            mdBus.mdStall = mdBus.startE | mdBus.readHiLoD;
         end
         default: nextState = IDLE;
      endcase
   end

   // One iteration step and final sign fix-up, from the latched operands
   always_comb begin
      mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opA} : '0);
      remShift = {rem, acc[WIDTH-1]};
      remDiff  = remShift - {1'b0, opB};
      prod     = negRes ? -acc : acc;
      quoFix   = divZero ? '1 : (negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
      remFix   = negRem ? -rem : rem;
   end

   // Operand capture, iteration datapath and HI/LO writes
   always_ff @(posedge clk) begin
      if (rst) begin
         mdBus.hi <= '0;
         mdBus.lo <= '0;
         cnt      <= '0;
         opA      <= '0;
         opB      <= '0;
         acc      <= '0;
         rem      <= '0;
         isDiv    <= 1'b0;
         negRes   <= 1'b0;
         negRem   <= 1'b0;
         divZero  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mdBus.startE) begin
                  if (isArithE) begin
                     // Divide keeps the dividend/quotient in the low half of acc
                     opA     <= magA;
                     opB     <= magB;
                     acc     <= {{WIDTH{1'b0}}, (isDivE ? magA : magB)};
                     rem     <= '0;
                     cnt     <= '0;
                     isDiv   <= isDivE;
                     negRes  <= signAE ^ signBE;
                     negRem  <= signAE;
                     divZero <= isDivE & (mdBus.srcBE == '0);
                  end else if (opE == OP_MTHI) begin
                     mdBus.hi <= mdBus.srcAE;
                  end else if (opE == OP_MTLO) begin
                     mdBus.lo <= mdBus.srcAE;
                  end
               end
            end
            CALC: begin
               cnt <= cnt + CNT_BITS'(1);
               if (isDiv) begin
                  rem <= remDiff[WIDTH] ? remShift[WIDTH-1:0] : remDiff[WIDTH-1:0];
                  acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~remDiff[WIDTH]};
               end else begin
                  acc <= {mulSum, acc[WIDTH-1:1]};
               end
            end
            FIX: begin
               if (isDiv) begin
                  mdBus.lo <= quoFix;
                  mdBus.hi <= remFix;
               end else begin
                  mdBus.hi <= prod[2*WIDTH-1:WIDTH];
                  mdBus.lo <= prod[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: vector table plus a scoreboard queue of
// expected HI/LO values, with hand-written stall and reset sequences.
module tb_md_unit;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;

   md_if #(.WIDTH(W)) bus ();

   md_unit #(.WIDTH(W), .CNT_BITS(6)) dut (
      .clk   (clk),
      .rst   (rst),
      .mdBus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, hi, lo;
   } vec_t;

   typedef struct {
      logic [31:0] hi, lo;
   } exp_t;

   exp_t        sb[$];
   vec_t        vecs[10];
   int          tests = 0;
   int          fails = 0;
   logic [31:0] prevHi, prevLo;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t          e;
      longint        sa, sb2, sp, sq, sr;
      longint unsigned up;
      sa  = longint'($signed(a));
      sb2 = longint'($signed(b));
      e.hi = '0;
      e.lo = '0;
      case (op)
         3'd1: begin sp = sa * sb2; e.hi = sp[63:32]; e.lo = sp[31:0]; end
         3'd2: begin up = {32'd0, a} * {32'd0, b}; e.hi = up[63:32]; e.lo = up[31:0]; end
         3'd3: begin
            if (b == 0) begin e.lo = '1; e.hi = a; end
            else begin sq = sa / sb2; sr = sa % sb2; e.lo = sq[31:0]; e.hi = sr[31:0]; end
         end
         3'd4: begin
            if (b == 0) begin e.lo = '1; e.hi = a; end
            else begin e.lo = a / b; e.hi = a % b; end
         end
         default: ;
      endcase
      return e;
   endfunction

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
      exp_t e;
      e.hi = eh;
      e.lo = el;
      sb.push_back(e);
      bus.startE = 1'b1;
      bus.mdOpE  = op;
      bus.srcAE  = a;
      bus.srcBE  = b;
      tick();
      bus.startE = 1'b0;
   endtask

   task automatic waitDone(input string name);
      int   n;
      exp_t e;
      n = 0;
      while (bus.busy && n < 100) begin
         tick();
         n++;
      end
      check({name, " busy cycles"}, n, 33);
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s: got no expected entry expected one queued", name);
      end else begin
         e = sb.pop_front();
         check({name, " hi"}, bus.hi, e.hi);
         check({name, " lo"}, bus.lo, e.lo);
         prevHi = e.hi;
         prevLo = e.lo;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   n;
      logic [2:0]  rop;
      logic [31:0] ra, rb;

      vecs[0] = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
      vecs[1] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{3'd4, 32'd100,      32'd7,        32'd2,        32'd14};
      vecs[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5] = '{3'd4, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
      vecs[6] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      vecs[7] = '{3'd1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
      vecs[8] = '{3'd3, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF};
      vecs[9] = '{3'd2, 32'd3,        32'd4,        32'd0,        32'd12};

      rst           = 1'b1;
      bus.startE    = 1'b0;
      bus.mdOpE     = 3'd0;
      bus.srcAE     = '0;
      bus.srcBE     = '0;
      bus.readHiLoD = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset hi", bus.hi, 0);
      check("reset lo", bus.lo, 0);
      check("reset busy", bus.busy, 0);
      check("reset mdStall", bus.mdStall, 0);

      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
         waitDone($sformatf("vec%0d", i));
      end

      for (int i = 0; i < 8; i++) begin
         rop = 3'($urandom_range(1, 4));
         ra  = $urandom;
         rb  = (i == 3) ? 32'd0 : $urandom;
         if (i == 5) rb = 32'd3;
         e = model(rop, ra, rb);
         issue(rop, ra, rb, e.hi, e.lo);
         waitDone($sformatf("rnd%0d op%0d", i, rop));
      end

      // MTHI/MTLO while idle; MTxx with MFxx in D does not stall
      bus.startE    = 1'b1;
      bus.mdOpE     = 3'd5;
      bus.srcAE     = 32'h1234;
      bus.readHiLoD = 1'b1;
      #1;
      check("mthi+mf mdStall", bus.mdStall, 0);
      tick();
      bus.startE    = 1'b0;
      bus.readHiLoD = 1'b0;
      check("mthi hi", bus.hi, 32'h1234);
      check("mthi busy", bus.busy, 0);
      check("mthi lo kept", bus.lo, prevLo);
      bus.startE = 1'b1;
      bus.mdOpE  = 3'd6;
      bus.srcAE  = 32'hCAFE0001;
      tick();
      bus.startE = 1'b0;
      check("mtlo lo", bus.lo, 32'hCAFE0001);
      check("mtlo hi kept", bus.hi, 32'h1234);
      prevHi = 32'h1234;
      prevLo = 32'hCAFE0001;

      // Idle arith start with MFxx in D stalls; withdraw before the edge
      bus.startE    = 1'b1;
      bus.mdOpE     = 3'd1;
      bus.readHiLoD = 1'b1;
      #1;
      check("idle mult+mf mdStall", bus.mdStall, 1);
      bus.startE    = 1'b0;
      bus.readHiLoD = 1'b0;
      #1;
      check("idle quiet mdStall", bus.mdStall, 0);
      tick();

      // Stall sequence: MULT busy, MF in D from cycle 3, DIV offered at cycle 10
      issue(3'd1, 32'hFFFFFFF6, 32'd9, 32'hFFFFFFFF, 32'hFFFFFFA6);
      n = 0;
      while (bus.busy && n < 100) begin
         if (n == 3) bus.readHiLoD = 1'b1;
         if (n == 10) begin
            bus.startE = 1'b1;
            bus.mdOpE  = 3'd4;
            bus.srcAE  = 32'd100;
            bus.srcBE  = 32'd7;
         end
         #1;
         if (n >= 3) check($sformatf("stall c%0d mdStall", n), bus.mdStall, 1);
         if (n == 20) begin
            check("stall mid hi", bus.hi, prevHi);
            check("stall mid lo", bus.lo, prevLo);
         end
         tick();
         n++;
      end
      check("stall busy cycles", n, 33);
      e = sb.pop_front();
      check("stall mult hi", bus.hi, e.hi);
      check("stall mult lo", bus.lo, e.lo);
      check("held div mdStall", bus.mdStall, 1);
      e.hi = 32'd2;
      e.lo = 32'd14;
      sb.push_back(e);
      tick();
      bus.startE    = 1'b0;
      bus.readHiLoD = 1'b0;
      waitDone("held div");

      // Reset mid-divide aborts without touching hi/lo beyond clearing them
      issue(3'd3, 32'h00001000, 32'd3, 32'd1, 32'd1365);
      n = 0;
      while (bus.busy && n < 15) begin
         tick();
         n++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      check("rst busy", bus.busy, 0);
      check("rst hi", bus.hi, 0);
      check("rst lo", bus.lo, 0);
      check("rst mdStall", bus.mdStall, 0);
      issue(3'd2, 32'd3, 32'd4, 32'd0, 32'd12);
      waitDone("post-rst multu");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
